// File: rtl/mem_port_arbiter.sv
// Arbiter that shares the single memory port between fetch (if_*) and the memory stage (dm_*).
// It runs one transaction at a time. Define MEM_ARB_RR_EN for round-robin tie-breaking; the default is fixed dm-over-if priority.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic              dm_byte,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_valid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic              mem_byte,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err,
  output logic [1:0]        dbgState  // 0 = IDLE, 1 = BUSY, 2 = RESP
);

  // Handshake: a requester raises *_req and holds it, with stable operands, until its
  // one-cycle *_valid. mem_req stays high until the one-cycle mem_ready pulse or the timeout.
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} stateT;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  stateT             state;
  logic              ownerDm;
  logic [7:0]        count;
  logic              grantDm;
  logic [DATA_W-1:0] loadValue;

`ifdef MEM_ARB_RR_EN
  logic lastDm;

  // On a tie, the requester that was not granted last wins. After reset, dm wins first.
  assign grantDm = dm_req && (!if_req || !lastDm);

  always_ff @(posedge clk) begin
    if (reset) begin
      lastDm <= 1'b0;
    end else if (state == IDLE && (dm_req || if_req)) begin
      lastDm <= grantDm;
    end
  end
`else
  assign grantDm = dm_req;
`endif

  assign if_stall = if_req && !if_valid;
  assign dm_stall = dm_req && !dm_valid;
  assign dbgState = state;

  always_comb begin
    loadValue = mem_rdata;
    if (mem_we) begin
      loadValue = '0;
    end else if (mem_byte) begin
      loadValue = {{(DATA_W-8){mem_rdata[7]}}, mem_rdata[7:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ownerDm   <= 1'b0;
      count     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_byte  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_valid  <= 1'b0;
      dm_valid  <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (dm_req || if_req) begin
            ownerDm   <= grantDm;
            mem_req   <= 1'b1;
            mem_addr  <= grantDm ? dm_addr : if_addr;
            mem_we    <= grantDm && dm_we;
            mem_byte  <= grantDm && dm_byte;
            mem_wdata <= grantDm ? dm_wdata : '0;
            count     <= '0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            state   <= RESP;
            if (ownerDm) begin
              dm_valid <= 1'b1;
              dm_rdata <= loadValue;
            end else begin
              if_valid <= 1'b1;
              if_rdata <= mem_rdata;
            end
          end else if (count == TIMEOUT_CNT) begin
            // The memory never answered: abort with a zero result and flag the error for good.
            mem_req <= 1'b0;
            err     <= 1'b1;
            state   <= RESP;
            if (ownerDm) begin
              dm_valid <= 1'b1;
              dm_rdata <= '0;
            end else begin
              if_valid <= 1'b1;
              if_rdata <= '0;
            end
          end else begin
            count <= count + 8'd1;
          end
        end
        RESP: begin
          if_valid <= 1'b0;
          dm_valid <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
